// File: rtl/os_systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : os_systolic_pkg
// Purpose  : Shared types and constants for the output-stationary systolic
//            array, its feeder controller and the result drain.
//            - drain_state_t : result-drain FSM states
//            - OP_COMPUTE / OP_SHIFT : array op-select encodings
// Revision : 1.0  initial release
// ============================================================================
package os_systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      STREAM = 2'd2
   } drain_state_t;

   localparam logic OP_COMPUTE = 1'b0;
   localparam logic OP_SHIFT   = 1'b1;

endpackage : os_systolic_pkg
`default_nettype wire

// File: rtl/os_drain_buf.sv
`default_nettype none
// ============================================================================
// Module   : os_drain_buf
// Purpose  : Tile buffer for the result drain. DEPTH entries of WIDTH bits,
//            one synchronous write port, one asynchronous read port. Data is
//            not reset.
// Ports    : clk      in  clock
//            wr_en    in  write enable
//            wr_addr  in  write entry index
//            wr_data  in  write vector
//            rd_addr  in  read entry index
//            rd_data  out read vector (combinational)
// Revision : 1.0  initial release
// ============================================================================
module os_drain_buf #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 80,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : os_drain_buf
`default_nettype wire

// File: rtl/os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : os_result_drain
// Purpose  : Unload side of the output-stationary systolic array. On start it
//            puts the array into shift mode for COLUMN cycles, captures one
//            result vector per cycle into a tile buffer and streams the
//            buffered vectors downstream over valid/ready, overlapping the
//            stream with the shift.
// Ports    : clk         in  clock
//            rst         in  synchronous active-high reset
//            start       in  begin a drain (only honoured in IDLE)
//            op_sel      out array op-select (OP_SHIFT during SHIFT)
//            result_in   out array result-chain input, always zero
//            result_out  in  array result-chain output
//            m_valid     out stream beat valid
//            m_ready     in  stream beat ready
//            m_data      out stream vector
//            m_col       out physical array column of the vector
//            m_last      out final beat of the tile
//            busy        out drain in progress
//            done        out pulse the cycle after the last beat is accepted
// Revision : 1.0  initial release
// ============================================================================
module os_result_drain
   import os_systolic_pkg::*;
#(
   parameter  int OUT_WORD_SIZE = 16,
   parameter  int ROW           = 5,
   parameter  int COLUMN        = 5,
   localparam int COL_W         = ($clog2(COLUMN) > 0) ? $clog2(COLUMN) : 1,
   localparam int VEC_W         = ROW * OUT_WORD_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             op_sel,
   output logic [VEC_W-1:0] result_in,
   input  logic [VEC_W-1:0] result_out,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [VEC_W-1:0] m_data,
   output logic [COL_W-1:0] m_col,
   output logic             m_last,
   output logic             busy,
   output logic             done
);

   // Pointers must be able to hold COLUMN itself (buffer full).
   localparam int PTR_W = $clog2(COLUMN + 1);

   drain_state_t     state;
   drain_state_t     state_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             accept;
   logic             last_beat;
   logic             last_accept;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // wr_ptr doubles as the shift-cycle counter: one entry is written in
   // every shift cycle, so it reaches COLUMN-1 in the final one.
   always_comb begin
      state_nxt = state;
      op_sel    = OP_COMPUTE;
      wr_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            op_sel = OP_SHIFT;
            wr_en  = 1'b1;
            if (wr_ptr == PTR_W'(COLUMN - 1)) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (last_accept) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Stream handshake
   // ------------------------------------------------------------------
   // The last beat can only be offered once all COLUMN entries are
   // written, so last_accept only ever occurs in STREAM.
   assign m_valid     = (rd_ptr < wr_ptr);
   assign accept      = m_valid & m_ready;
   assign last_beat   = (rd_ptr == PTR_W'(COLUMN - 1));
   assign last_accept = accept & last_beat;
   assign m_last      = m_valid & last_beat;
   assign m_col       = m_valid ? (COL_W'(COLUMN - 1) - rd_ptr[COL_W-1:0]) : '0;
   assign busy        = (state != IDLE);
   assign result_in   = '0;

   // Pointers return to zero on the final acceptance so IDLE always holds
   // rd_ptr == wr_ptr == 0 and a new start needs no extra clearing.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         done   <= 1'b0;
      end else begin
         done <= last_accept;
         if (last_accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (accept) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Tile buffer
   // ------------------------------------------------------------------
   os_drain_buf #(
      .DEPTH (COLUMN),
      .WIDTH (VEC_W),
      .AW    (COL_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[COL_W-1:0]),
      .wr_data (result_out),
      .rd_addr (rd_ptr[COL_W-1:0]),
      .rd_data (m_data)
   );

endmodule : os_result_drain
`default_nettype wire

// File: tb/tb_os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_result_drain
// Purpose  : Self-checking bench for os_result_drain. A tile-level reference
//            model tracks how many vectors have been shifted out of the array
//            and how many beats have been accepted; every cycle the DUT
//            outputs are compared against what that model predicts.
// Revision : 1.0  initial release
// ============================================================================
module tb_os_result_drain;

   localparam int OUT_WORD_SIZE = 16;
   localparam int ROW           = 5;
   localparam int COLUMN        = 5;
   localparam int COL_W         = 3;
   localparam int VEC_W         = ROW * OUT_WORD_SIZE;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             op_sel;
   logic [VEC_W-1:0] result_in;
   logic [VEC_W-1:0] result_out;
   logic             m_valid;
   logic             m_ready;
   logic [VEC_W-1:0] m_data;
   logic [COL_W-1:0] m_col;
   logic             m_last;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;

   // Reference model: a tile in flight has shift_k vectors captured and
   // acc beats accepted; vector k of the tile is tile[k].
   bit               draining = 1'b0;
   bit               exp_done = 1'b0;
   int               shift_k  = 0;
   int               acc      = 0;
   int               tile_no  = 0;
   logic [VEC_W-1:0] tile [COLUMN];

   always #5 clk = ~clk;

   os_result_drain #(
      .OUT_WORD_SIZE (OUT_WORD_SIZE),
      .ROW           (ROW),
      .COLUMN        (COLUMN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op_sel     (op_sel),
      .result_in  (result_in),
      .result_out (result_out),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_col      (m_col),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [VEC_W-1:0] rand_vec();
      logic [VEC_W-1:0] v;
      v = '0;
      for (int r = 0; r < ROW; r++) begin
         v[r*OUT_WORD_SIZE +: OUT_WORD_SIZE] = OUT_WORD_SIZE'($urandom);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [VEC_W-1:0] obs,
                      input logic [VEC_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First tile uses the 100+k pattern, later tiles are random.
   task automatic new_tile();
      tile_no++;
      for (int k = 0; k < COLUMN; k++) begin
         if (tile_no == 1) begin
            tile[k] = {ROW{OUT_WORD_SIZE'(100 + k)}};
         end else begin
            tile[k] = rand_vec();
         end
      end
   endtask

   // One clock cycle: drive inputs, check outputs, clock, advance model.
   task automatic cycle(input logic st, input logic rdy, input logic rs,
                        input bit do_check);
      bit exp_op;
      bit exp_valid;
      start     = st;
      m_ready   = rdy;
      rst       = rs;
      exp_op    = draining && (shift_k < COLUMN);
      exp_valid = draining && (acc < shift_k);
      // Array model: presents the next vector only while it is being shifted.
      result_out = exp_op ? tile[shift_k] : rand_vec();
      #1;
      if (do_check) begin
         chk("op_sel",    VEC_W'(op_sel),    VEC_W'(exp_op));
         chk("busy",      VEC_W'(busy),      VEC_W'(draining));
         chk("done",      VEC_W'(done),      VEC_W'(exp_done));
         chk("result_in", result_in,         '0);
         chk("m_valid",   VEC_W'(m_valid),   VEC_W'(exp_valid));
         if (exp_valid) begin
            chk("m_data", m_data,         tile[acc]);
            chk("m_col",  VEC_W'(m_col),  VEC_W'(COLUMN - 1 - acc));
            chk("m_last", VEC_W'(m_last), VEC_W'(acc == COLUMN - 1));
         end else begin
            chk("m_last_idle", VEC_W'(m_last), '0);
         end
      end
      @(posedge clk);
      if (rs) begin
         draining = 1'b0;
         exp_done = 1'b0;
         shift_k  = 0;
         acc      = 0;
      end else begin
         exp_done = exp_valid && rdy && (acc == COLUMN - 1);
         if (draining) begin
            if (exp_op) shift_k++;
            if (exp_valid && rdy) acc++;
            if (acc == COLUMN) draining = 1'b0;
         end else if (st) begin
            draining = 1'b1;
            shift_k  = 0;
            acc      = 0;
            new_tile();
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bit hit;
      start      = 1'b0;
      m_ready    = 1'b0;
      rst        = 1'b1;
      result_out = '0;

      // Reset, then confirm reset state.
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 1: full drain, always ready.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 2: consumer stalled for 10 cycles after start.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 3: ready toggling 1,0,1,0...
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) cycle(1'b0, (i % 2) == 1, 1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 4: start again at shift cycle 2 is ignored.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 5: reset at shift cycle 3, then a fresh full drain.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 6: start in the same cycle as done.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (exp_done) begin
            hit = 1'b1;
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
         end else begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
         end
      end
      chk("done_reached", VEC_W'(hit), VEC_W'(1));
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 7: random traffic with occasional reset.
      repeat (400) begin
         cycle(($urandom % 8) == 0, ($urandom % 2) == 1,
               ($urandom % 64) == 0, 1'b1);
      end
      repeat (15) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_os_result_drain
`default_nettype wire
